// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

  // Operation codes, kept identical to the earlier single-cycle ALU.
  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_LSL   = 4'b0011,
    OP_LSR   = 4'b0100,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {N, Z, C, V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, N cycles.
// product is the accumulator value after the current iteration, so it is
// exactly the final low-N-bit product in the cycle where done is high.
module alu_mul_iter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  mcand, mplier, acc;
  logic [CW-1:0] cnt;

  assign product = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CW'(N - 1));

  // Load operands on start, then run one shift-add step per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops plus an iterative
// multiply, valid/ready on both sides, registered result and NZCV flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alu_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         illegal
);
  localparam int SW = $clog2(N);

  state_t       state, state_nxt;
  alu_op_t      op;
  logic         accept, is_mul, load_alu, mul_start;
  logic         mul_busy, mul_done;
  logic [N-1:0] mul_prod;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flags, mul_flags;
  logic         alu_ill;
  logic [N:0]   sum, diff;

  assign op        = alu_op_t'(alu_op);
  assign is_mul    = (op == OP_MUL);
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  alu_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and load strobes; DONE with out_ready behaves like IDLE.
  always_comb begin
    state_nxt = state;
    load_alu  = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end else begin
            load_alu  = 1'b1;
            state_nxt = DONE;
          end
        end else if (state == DONE && out_ready) begin
          state_nxt = IDLE;
        end
      end
      MUL: begin
        if (mul_done)       state_nxt = DONE;
        else if (!mul_busy) state_nxt = IDLE;  // multiplier lost its job; recover
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);  // top bit = NOT borrow

  // Single-cycle datapath and its flags.
  always_comb begin
    alu_res   = '0;
    alu_ill   = 1'b0;
    alu_flags = '0;
    case (op)
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_ADD: begin
        alu_res           = sum[N-1:0];
        alu_flags[FLAG_C] = sum[N];
        alu_flags[FLAG_V] = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res           = diff[N-1:0];
        alu_flags[FLAG_C] = diff[N];
        alu_flags[FLAG_V] = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_LSL:   alu_res = a << b[SW-1:0];
      OP_LSR:   alu_res = a >> b[SW-1:0];
      OP_PASSB: alu_res = b;
      default: begin
        alu_res = '1;
        alu_ill = 1'b1;
      end
    endcase
    if (alu_ill) begin
      alu_flags = '0;
    end else begin
      alu_flags[FLAG_N] = alu_res[N-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
    end
  end

  // Multiply only produces N and Z; C and V stay clear.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[N-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
  end

  // Output registers; they hold while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result  <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else if (load_alu) begin
      result  <= alu_res;
      flags   <= alu_flags;
      illegal <= alu_ill;
    end else if (mul_done && state == MUL) begin
      result  <= mul_prod;
      flags   <= mul_flags;
      illegal <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath's execute stage. It is the successor to the single-cycle combinational ALU and keeps that block's operation encodings. It adds logical shifts, an iterative shift-add multiply and registered NZCV flags. Operands enter and results leave through valid/ready handshakes, so the pipeline control can stall around the variable multiply latency.

## Interface
- N, 64: operand and result width; power of two, ≥ 4.
- SW, $clog2(N): shift-amount width (derived, not overridden).

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op request valid.
- in_ready  out  1  block can accept a request this cycle.
- a  in  N  operand A.
- b  in  N  operand B; b[SW-1:0] is the shift amount for shift ops.
- alu_op  in  4  operation code (alu_pkg::alu_op_t).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  N  registered result.
- flags  out  4  registered {N, Z, C, V}.
- illegal  out  1  registered; set when the accepted alu_op was unsupported.

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a−b); 0111 PASSB.
  - 0011 LSL: a << b[SW-1:0].
  - 0100 LSR: logical a >> b[SW-1:0].
  - 1000 MUL: low N bits of a*b, unsigned.
  - Any other code: result = all ones, illegal = 1, flags = 0.
- Flags:
  - N = result[N-1].
  - Z = (result == 0).
  - ADD: C = carry-out of bit N-1; V = signed overflow.
  - SUB: C = NOT borrow (1 when a ≥ b unsigned); V = signed overflow of a−b.
  - All other ops: C = V = 0.
- All arithmetic is N bits wide and wraps. Shift amounts are taken modulo N; amount 0 passes a unchanged.
- Handshake: a request is accepted when in_valid && in_ready. a, b and alu_op are sampled only at acceptance.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- States:
  - IDLE: waiting for a request. An accepted single-cycle op loads result/flags/illegal and goes to DONE. An accepted MUL loads the multiplier registers and goes to MUL.
  - MUL: one shift-add iteration per cycle. Per iteration: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. After the N-th iteration, load result/flags and go to DONE.
  - DONE: out_valid = 1.
    - result, flags and illegal hold stable while out_ready = 0.
    - On out_ready with no new accept, go to IDLE.
    - On out_ready with a simultaneous accept, process the new request exactly as from IDLE (back-to-back).
- Inputs a, b and alu_op are ignored while in MUL.
- in_valid while not ready is not an error; the request simply waits.

## Timing
- Reset (async assert, synchronous release effect):
  - state = IDLE; out_valid = 0; result = 0; flags = 0; illegal = 0; multiplier registers = 0.
  - in_ready = 1 in the first cycle after release.
- Single-cycle ops: accepted at edge k, out_valid = 1 after edge k (latency 1). Sustained throughput is 1 op/cycle when out_ready is held high.
- MUL: accepted at edge k; iterations run at edges k+1 … k+N; out_valid = 1 after edge k+N (latency N+1). in_ready = 0 from edge k until the result is consumed.
- Reset asserted mid-MUL or in DONE discards the operation immediately. No stale out_valid appears after release.
- out_valid never drops without an out_ready handshake, except on reset.

## Structure
- Package alu_pkg holds:
  - alu_op_t enum (4-bit) with the codes above.
  - state_t enum {IDLE, MUL, DONE}.
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_mul_iter, parameterised by N.
  - Signals: start, busy, done (1-cycle pulse) and an N-bit product.
  - Holds the mcand, mplier, acc and cnt registers.
  - Has its own async active-low reset.
- The top level holds the FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
- Reset: hold reset_n = 0 mid-MUL at cycle 10 → out_valid = 0, result = 0, flags = 0, in_ready = 1 after release; no spurious result.
- ADD/SUB flags (N=64):
  - ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result 64'h8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1.
  - SUB a=5, b=5 → result 0, Z=1, C=1.
  - SUB a=3, b=5 → result 64'hFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- Shifts/logic:
  - LSL a=1, b=65 → result 2 (amount mod 64).
  - LSR a=64'h8000_0000_0000_0000, b=63 → result 1.
  - AND 64'hF0 & 64'h3C → 64'h30.
  - PASSB b=0 → Z=1.
- MUL: a=123456789, b=1000 → result 123456789000 exactly 65 cycles after accept; in_ready = 0 throughout. Also a=2^63, b=2 → 0 (wrap), Z=1.
- Back-pressure and back-to-back:
  - Hold out_ready = 0 for 5 cycles → result stable and in_ready = 0.
  - Then stream 8 ADDs with out_ready = 1 → one result per cycle, in order.
- Illegal op: alu_op = 4'b1111 → result all ones, illegal = 1, flags = 0. The next legal op clears illegal.
